// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the 8-bit XNOR LFSR (taps 7,5,4,3) random-bit stream.
// Define PRBS8_CHK_BITCNT_EN to build the checked-bit counter; otherwise bit_cnt_o reads 0.

// state    | meaning
// ---------+-------------------------------------------------------------
// S_HUNT   | loading 8 received bits straight into the shadow register
// S_VERIFY | predicting each bit, counting consecutive correct predictions
// S_LOCKED | flywheel on own prediction, flagging and counting mismatches
module prbs8_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_ERR = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             bit_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_ERR - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_sh;
    logic [2:0]         r_fill;
    logic [7:0]         r_match;
    logic [3:0]         r_miss;
    logic               r_err;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_pred;
    logic               w_hit;
    logic               w_miss_bit;
    logic               w_sh_ok;
    logic               w_err_inc;

    assign w_pred     = ~(r_sh[7] ^ r_sh[5] ^ r_sh[4] ^ r_sh[3]);
    assign w_hit      = en_i & (bit_i == w_pred);
    assign w_miss_bit = en_i & (bit_i != w_pred);
    // All-ones is the XNOR lock-up state: it predicts itself, so it never counts as sync.
    assign w_sh_ok    = (r_sh != 8'hFF);
    assign w_err_inc  = (r_state == S_LOCKED) & w_miss_bit;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_HUNT: begin
                if (en_i && (r_fill == 3'd7)) w_state_nxt = S_VERIFY;
            end
            S_VERIFY: begin
                if (w_hit && w_sh_ok && (r_match == LOCK_LAST)) w_state_nxt = S_LOCKED;
            end
            S_LOCKED: begin
                if (w_miss_bit && (r_miss == LOSS_LAST)) w_state_nxt = S_HUNT;
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    always_comb begin
        locked_o = (r_state == S_LOCKED);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sh    <= 8'h00;
            r_fill  <= 3'd0;
            r_match <= 8'd0;
            r_miss  <= 4'd0;
        end else if (en_i) begin
            unique case (r_state)
                S_HUNT: begin
                    r_sh    <= {r_sh[6:0], bit_i};
                    r_fill  <= r_fill + 3'd1;
                    r_match <= 8'd0;
                end
                S_VERIFY: begin
                    r_sh   <= {r_sh[6:0], bit_i};
                    r_miss <= 4'd0;
                    if (w_hit && w_sh_ok) begin
                        r_match <= r_match + 8'd1;
                    end else begin
                        r_match <= 8'd0;
                    end
                end
                S_LOCKED: begin
                    // Flywheel: shift our own prediction so line errors cannot corrupt the shadow.
                    r_sh   <= {r_sh[6:0], w_pred};
                    r_fill <= 3'd0;
                    if (w_miss_bit) begin
                        r_miss <= r_miss + 4'd1;
                    end else if (r_miss != 4'd0) begin
                        r_miss <= r_miss - 4'd1;
                    end
                end
                default: begin
                    r_sh   <= 8'h00;
                    r_fill <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_err_inc;
            if (clr_i) begin
                r_err_cnt <= '0;
            end else if (w_err_inc && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;

`ifdef PRBS8_CHK_BITCNT_EN
    logic [CNT_W-1:0] r_bit_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bit_cnt <= '0;
        end else if (clr_i) begin
            r_bit_cnt <= '0;
        end else if (en_i && (r_state == S_LOCKED) && (r_bit_cnt != '1)) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
    end

    assign bit_cnt_o = r_bit_cnt;
`else
    assign bit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: reference generator plus a per-bit behavioural model of the checker,
// compared against the DUT every cycle, with a few literal anchors from the test plan.
module tb_prbs8_checker;

    localparam int CNT_W    = 10;
    localparam int LOCK_CNT = 16;
    localparam int LOSS_ERR = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;
    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             en_i  = 1'b0;
    logic             bit_i = 1'b0;
    logic             clr_i = 1'b0;
    logic             locked_o;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] bit_cnt_o;

    prbs8_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_ERR (LOSS_ERR),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .bit_i     (bit_i),
        .clr_i     (clr_i),
        .locked_o  (locked_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o),
        .bit_cnt_o (bit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int g_st = 0;
    int m_mode, m_sh, m_fill, m_match, m_miss, m_locked, m_err, m_errcnt, m_bitcnt;

    // XNOR of taps 7,5,4,3 is 1 exactly when those four bits have even parity.
    function automatic int pred_of(input int s);
        return (($countones(s & 'hB8) % 2) == 0) ? 1 : 0;
    endfunction

    function automatic int exp_bitcnt(input int v);
`ifdef PRBS8_CHK_BITCNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic gen_bit(output int b);
        b = pred_of(g_st);
        g_st = ((g_st << 1) | b) & 255;
    endtask

    task automatic model_reset();
        m_mode = M_HUNT; m_sh = 0; m_fill = 0; m_match = 0; m_miss = 0;
        m_locked = 0; m_err = 0; m_errcnt = 0; m_bitcnt = 0;
    endtask

    task automatic model_step(input bit en, input bit b, input bit clr);
        int p;
        m_err = 0;
        if (en) begin
            p = pred_of(m_sh);
            if (m_mode == M_HUNT) begin
                m_sh = ((m_sh << 1) | b) & 255;
                m_fill++;
                if (m_fill == 8) begin
                    m_mode  = M_VERIFY;
                    m_match = 0;
                end
            end else if (m_mode == M_VERIFY) begin
                if (b == p && m_sh != 255) m_match++;
                else m_match = 0;
                m_sh = ((m_sh << 1) | b) & 255;
                if (m_match == LOCK_CNT) begin
                    m_mode = M_LOCKED;
                    m_miss = 0;
                end
            end else begin
                if (m_bitcnt < CMAX) m_bitcnt++;
                m_sh = ((m_sh << 1) | p) & 255;
                if (b != p) begin
                    m_err = 1;
                    if (m_errcnt < CMAX) m_errcnt++;
                    m_miss++;
                    if (m_miss == LOSS_ERR) begin
                        m_mode = M_HUNT;
                        m_fill = 0;
                    end
                end else if (m_miss > 0) begin
                    m_miss--;
                end
            end
        end
        if (clr) begin
            m_errcnt = 0;
            m_bitcnt = 0;
        end
        m_locked = (m_mode == M_LOCKED) ? 1 : 0;
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("locked_o", locked_o, m_locked);
            check("err_o", err_o, m_err);
            check("err_cnt_o", err_cnt_o, m_errcnt);
            check("bit_cnt_o", bit_cnt_o, exp_bitcnt(m_bitcnt));
        end
    end

    task automatic step(input bit en, input bit b, input bit clr);
        en_i = en; bit_i = b; clr_i = clr;
        @(posedge clk_i);
        model_step(en, b, clr);
        #1;
    endtask

    task automatic sbit(input bit flip, input bit clr);
        int b;
        gen_bit(b);
        step(1'b1, b[0] ^ flip, clr);
    endtask

    task automatic stream_until_lock(input int duty, output int n);
        int b;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(99) < duty) begin
                gen_bit(b);
                step(1'b1, b[0], 1'b0);
                n++;
            end else begin
                step(1'b0, 1'($urandom_range(1)), 1'b0);
            end
            if (locked_o) break;
        end
    endtask

    task automatic reset_mid();
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_locked", locked_o, 0);
        check("rst_err", err_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);
        check("rst_bit_cnt", bit_cnt_o, 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        int n, x, b;
        model_reset();
        en_i = 1'b0; bit_i = 1'b0; clr_i = 1'b0;
        #3;
        check("por_locked", locked_o, 0);
        check("por_err_cnt", err_cnt_o, 0);
        @(posedge clk_i);
        #1;
        rst_i  = 1'b1;
        chk_en = 1'b1;

        // Generator anchor: from seed 0 the first eight bits are 1,1,1,1,0,1,0,0.
        g_st = 0;
        x = 0;
        for (int i = 0; i < 8; i++) begin
            gen_bit(b);
            x = (x << 1) | b;
        end
        check("gen_first8", x, 'hF4);
        g_st = 0;

        // Continuous valid stream from seed 0: lock on the 24th bit, clean over 1000 bits.
        stream_until_lock(100, n);
        check("lock_latency_cont", n, 24);
        for (int i = n; i < 1000; i++) sbit(1'b0, 1'b0);
        check("err_cnt_1000", err_cnt_o, 0);
        check("bit_cnt_1000", bit_cnt_o, exp_bitcnt(976));

        // Single flipped bit: one pulse, flywheel keeps the next bits clean.
        step(1'b0, 1'b0, 1'b1);
        sbit(1'b1, 1'b0);
        check("single_err_pulse", err_o, 1);
        check("single_err_cnt", err_cnt_o, 1);
        for (int i = 0; i < 8; i++) sbit(1'b0, 1'b0);
        check("single_err_after8", err_cnt_o, 1);
        check("single_locked", locked_o, 1);

        // Four consecutive bad bits drop lock on the fourth, then relock after 24 valid bits.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) sbit(1'b1, 1'b0);
        check("burst3_locked", locked_o, 1);
        sbit(1'b1, 1'b0);
        check("burst4_locked", locked_o, 0);
        check("burst4_err_cnt", err_cnt_o, 4);
        stream_until_lock(100, n);
        check("relock_latency", n, 24);

        // Clear coinciding with an error: pulse still fires, counter reads 0.
        step(1'b0, 1'b0, 1'b1);
        sbit(1'b1, 1'b1);
        check("clr_err_pulse", err_o, 1);
        check("clr_err_cnt", err_cnt_o, 0);
        for (int i = 0; i < 8; i++) sbit(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            sbit(1'b1, 1'b0);
            sbit(1'b0, 1'b0);
            sbit(1'b0, 1'b0);
        end
        check("three_err_cnt", err_cnt_o, 3);
        step(1'b0, 1'b0, 1'b1);
        check("clr_mid_err_cnt", err_cnt_o, 0);
        check("clr_mid_bit_cnt", bit_cnt_o, 0);
        check("clr_mid_locked", locked_o, 1);

        // Alternating bad/good keeps lock and drives both counters into saturation.
        for (int i = 0; i < 1040; i++) begin
            sbit(1'b0, 1'b0);
            sbit(1'b1, 1'b0);
        end
        check("sat_locked", locked_o, 1);
        check("sat_err_cnt", err_cnt_o, CMAX);
        check("sat_bit_cnt", bit_cnt_o, exp_bitcnt(CMAX));

        // Async reset mid-stream, then lock through ~50% enable gaps.
        reset_mid();
        stream_until_lock(50, n);
        check("lock_latency_gaps", n, 24);

        // Randomised gaps, flips and clears against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1) == 1) begin
                sbit(($urandom_range(19) == 0), ($urandom_range(49) == 0));
            end else begin
                step(1'b0, 1'($urandom_range(1)), ($urandom_range(49) == 0));
            end
        end

        // Static streams never lock.
        reset_mid();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
        check("ones_locked", locked_o, 0);
        reset_mid();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
        check("zeros_locked", locked_o, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
